// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// It takes the forwarded execute-stage operands and holds F/D/E stalled while
// it iterates. It then presents the result for one cycle so the instruction can
// advance with it in place of the ALU result.
// Multiply is radix-2 shift-add and divide is restoring. Both run on operand
// magnitudes, and the sign is fixed up on the final iteration.
// Divide-by-zero and signed overflow resolve in the issue cycle and do not iterate.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   StartE         M-extension instruction present in E
//   MulDivOpE      funct3 of the M instruction
//   SrcAE, SrcBE   forwarded rs1 / rs2 values
//   FlushE         cancel the instruction in E
//   StallMD        stall request for F/D/E
//   BusyE          sequencer not idle (from the state register)
//   DoneE          result valid this cycle
//   MulDivResultE  registered result; meaningful only while DoneE=1
module muldiv_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             StallMD,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] MulDivResultE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;        // multiplicand magnitude
    logic [WIDTH-1:0] b_q, b_d;        // divisor magnitude
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    // hi/lo form the working pair. For a multiply they are the {partial
    // product, multiplier} pair. For a divide they are the {remainder,
    // dividend/quotient} pair.
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_div, signed_a, signed_b, sa_in, sb_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] hi_n, lo_n, quo_f, rem_f;
    logic [2*WIDTH-1:0] prod_f;

    always_comb begin
        is_div   = MulDivOpE[2];
        signed_a = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b010) ||
                   (MulDivOpE == 3'b100) || (MulDivOpE == 3'b110);
        signed_b = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b100) ||
                   (MulDivOpE == 3'b110);
        sa_in    = signed_a & SrcAE[WIDTH-1];
        sb_in    = signed_b & SrcBE[WIDTH-1];
        a_mag_in = sa_in ? (~SrcAE + 1'b1) : SrcAE;
        b_mag_in = sb_in ? (~SrcBE + 1'b1) : SrcBE;
    end

    // One iteration of the current operation, plus the sign-corrected final
    // result that is derived from it on the last iteration.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
                hi_n = div_trial[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod_f = (sa_q ^ sb_q) ? (~{hi_n, lo_n} + 1'b1) : {hi_n, lo_n};
        quo_f  = (sa_q ^ sb_q) ? (~lo_n + 1'b1) : lo_n;
        rem_f  = sa_q ? (~hi_n + 1'b1) : hi_n;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        StallMD  = 1'b0;
        DoneE    = 1'b0;

        if (FlushE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (StartE) begin
                        StallMD = 1'b1;
                        op_d    = MulDivOpE;
                        a_d     = a_mag_in;
                        b_d     = b_mag_in;
                        sa_d    = sa_in;
                        sb_d    = sb_in;
                        hi_d    = '0;
                        lo_d    = is_div ? a_mag_in : b_mag_in;
                        cnt_d   = '0;
                        state_d = BUSY;
                        if (is_div && (SrcBE == '0)) begin
                            result_d = MulDivOpE[1] ? SrcAE : '1;
                            state_d  = DONE;
                        end else if (is_div && !MulDivOpE[0] &&
                                     (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                     (SrcBE == '1)) begin
                            result_d = MulDivOpE[1] ? '0 : SrcAE;
                            state_d  = DONE;
                        end
                    end
                end
                BUSY: begin
                    StallMD = 1'b1;
                    hi_d    = hi_n;
                    lo_d    = lo_n;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        if (op_q[2])
                            result_d = op_q[1] ? rem_f : quo_f;
                        else
                            result_d = (op_q == 3'b000) ? prod_f[WIDTH-1:0]
                                                        : prod_f[2*WIDTH-1:WIDTH];
                    end
                end
                DONE: begin
                    DoneE   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // Reset holds every output low, including the combinational stall.
        if (rst) StallMD = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign BusyE         = (state_q != IDLE);
    assign MulDivResultE = result_q;

endmodule
